// File: rtl/adc_sum_trigger_pkg.sv
// Shared types, default widths and the saturating bias-subtract helper for adc_sum_trigger.
package adc_sum_trigger_pkg;

  localparam int ADC_W_DEF = 16;
  localparam int TRG_W_DEF = 16;
  localparam int LIM_W_DEF = 8;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    HOLDOFF  = 2'd2,
    REARM    = 2'd3
  } trg_state_e;

  // Operands arrive sign-extended to 32 bits; the result is clamped to the signed w-bit range.
  function automatic logic signed [31:0] sat_sub(
    input logic signed [31:0] x,
    input logic signed [31:0] bias,
    input int                 w
  );
    logic signed [32:0] diff;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    diff = {x[31], x} - {bias[31], bias};
    hi   = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo   = -(33'sd1 <<< (w - 1));
    if (diff > hi) begin
      sat_sub = hi[31:0];
    end else if (diff < lo) begin
      sat_sub = lo[31:0];
    end else begin
      sat_sub = diff[31:0];
    end
  endfunction

endpackage

// File: rtl/adc_sum_trigger_bias_abs.sv
// One ADC channel: subtract bias with saturation, take the magnitude, register both (pipeline stage 1).
module bias_abs
  import adc_sum_trigger_pkg::*;
#(
  parameter int W = ADC_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] bias_i,
  output logic [W-1:0] corr_o,
  output logic [W-1:0] abs_o
);

  logic signed [31:0] x_ext;
  logic signed [31:0] bias_ext;
  logic signed [31:0] corr_full;
  logic [W-1:0]       corr_d;
  logic [W-1:0]       abs_d;
  logic [W-1:0]       corr_q;
  logic [W-1:0]       abs_q;

  assign x_ext     = 32'(signed'(x_i));
  assign bias_ext  = 32'(signed'(bias_i));
  assign corr_full = sat_sub(x_ext, bias_ext, W);
  assign corr_d    = corr_full[W-1:0];
  // Unsigned W-bit magnitude, so the most negative code maps to 2^(W-1) without overflow.
  assign abs_d     = corr_d[W-1] ? (~corr_d + W'(1)) : corr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      corr_q <= '0;
      abs_q  <= '0;
    end else if (load_i) begin
      corr_q <= corr_d;
      abs_q  <= abs_d;
    end
  end

  assign corr_o = corr_q;
  assign abs_o  = abs_q;

endmodule

// File: rtl/adc_sum_trigger.sv
// Bias-corrected |A|+|B| threshold trigger with holdoff/re-arm, tagged onto a two-stage AXI-Stream pipe.
// Define ADC_SUM_TRIGGER_MAX_EN to build the peak-sum tracker; otherwise max_sum is tied to zero.
module adc_sum_trigger
  import adc_sum_trigger_pkg::*;
#(
  parameter int ADC_DATA_WIDTH  = ADC_W_DEF,
  parameter int TRG_VALUE_WIDTH = TRG_W_DEF,
  parameter int LIMITER_WIDTH   = LIM_W_DEF
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          trg_en,
  input  logic                          max_clr_n,
  input  logic [TRG_VALUE_WIDTH-1:0]    trg_value,
  input  logic [LIMITER_WIDTH-1:0]      limiter,
  input  logic [ADC_DATA_WIDTH-1:0]     bias_ch_A,
  input  logic [ADC_DATA_WIDTH-1:0]     bias_ch_B,
  input  logic [2*ADC_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [2*ADC_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tuser,
  output logic [31:0]                   trg_count,
  output logic [ADC_DATA_WIDTH:0]       max_sum
);

  localparam int W     = ADC_DATA_WIDTH;
  localparam int SUM_W = W + 1;
  localparam int CMP_W = (SUM_W > TRG_VALUE_WIDTH) ? SUM_W : TRG_VALUE_WIDTH;

  logic           s1_valid_q, s1_valid_d;
  logic           s2_valid_q, s2_valid_d;
  logic           ready1, ready2;
  logic           load1, load2;

  logic [W-1:0]   bias_ch [2];
  logic [W-1:0]   corr_s1 [2];
  logic [W-1:0]   abs_s1  [2];

  logic [SUM_W-1:0] sum_d;
  logic             hit;

  logic [2*W-1:0] data_q, data_d;
  logic           tuser_q, tuser_d;
  logic [31:0]    count_q, count_d;

  trg_state_e               state_q, state_d;
  logic [LIMITER_WIDTH-1:0] hold_q, hold_d;
  logic                     fire;

  // ---------------------------------------------------------------- handshake
  assign ready2 = ~s2_valid_q | m_axis_tready;
  assign ready1 = ~s1_valid_q | ready2;
  assign load1  = s_axis_tvalid & ready1;
  assign load2  = s1_valid_q & ready2;

  assign s1_valid_d = ready1 ? s_axis_tvalid : s1_valid_q;
  assign s2_valid_d = ready2 ? s1_valid_q    : s2_valid_q;

  // ---------------------------------------------------------------- stage 1
  assign bias_ch[0] = bias_ch_A;
  assign bias_ch[1] = bias_ch_B;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      bias_abs #(
        .W (W)
      ) u_bias_abs (
        .clk_i  (aclk),
        .rst_ni (aresetn),
        .load_i (load1),
        .x_i    (s_axis_tdata[gi*W +: W]),
        .bias_i (bias_ch[gi]),
        .corr_o (corr_s1[gi]),
        .abs_o  (abs_s1[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------- stage 2 datapath
  assign sum_d  = SUM_W'(abs_s1[0]) + SUM_W'(abs_s1[1]);
  assign hit    = CMP_W'(sum_d) >= CMP_W'(trg_value);
  assign data_d = load2 ? {corr_s1[1], corr_s1[0]} : data_q;

  // ---------------------------------------------------------------- trigger FSM
  // Only DISABLED and the trg_en override move without a beat; everything else waits for an S2 load.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    fire    = 1'b0;
    if (!trg_en) begin
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED: state_d = REARM;
        ARMED: begin
          if (load2 && hit) begin
            fire = 1'b1;
            if (limiter == '0) begin
              state_d = REARM;
            end else begin
              state_d = HOLDOFF;
              hold_d  = limiter;
            end
          end
        end
        HOLDOFF: begin
          if (load2) begin
            if (hold_q <= LIMITER_WIDTH'(2)) begin
              state_d = REARM;
            end else begin
              hold_d = hold_q - LIMITER_WIDTH'(1);
            end
          end
        end
        REARM: begin
          if (load2 && !hit) begin
            state_d = ARMED;
          end
        end
        default: state_d = DISABLED;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    tuser_d = tuser_q;
    if (!trg_en) begin
      count_d = '0;
    end else if (fire) begin
      count_d = count_q + 32'd1;
    end
    if (load2) begin
      tuser_d = fire;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      tuser_q    <= 1'b0;
      count_q    <= '0;
      state_q    <= DISABLED;
      hold_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      data_q     <= data_d;
      tuser_q    <= tuser_d;
      count_q    <= count_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
    end
  end

  // ---------------------------------------------------------------- peak tracker
`ifdef ADC_SUM_TRIGGER_MAX_EN
  logic [SUM_W-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (!max_clr_n) begin
      max_d = '0;
    end else if (load2 && (sum_d > max_q)) begin
      max_d = sum_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign max_sum = max_q;
`else
  logic unused_max_clr;
  assign unused_max_clr = max_clr_n;
  assign max_sum        = '0;
`endif

  // ---------------------------------------------------------------- outputs
  assign s_axis_tready = ready1;
  assign m_axis_tvalid = s2_valid_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tuser  = tuser_q;
  assign trg_count     = count_q;

endmodule

// File: tb/tb_adc_sum_trigger.sv
// Scoreboard bench for adc_sum_trigger: a per-beat reference model queues expected beats, a monitor checks them.
module tb_adc_sum_trigger;

  localparam int W = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          trg_en = 1'b0;
  logic          max_clr_n = 1'b1;
  logic [15:0]   trg_value = 16'd1000;
  logic [7:0]    limiter = 8'd0;
  logic [15:0]   bias_ch_A = 16'd0;
  logic [15:0]   bias_ch_B = 16'd0;
  logic [31:0]   s_axis_tdata = 32'd0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tuser;
  logic [31:0]   trg_count;
  logic [16:0]   max_sum;

  always #5 aclk = ~aclk;

  adc_sum_trigger #(
    .ADC_DATA_WIDTH  (16),
    .TRG_VALUE_WIDTH (16),
    .LIMITER_WIDTH   (8)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .trg_en        (trg_en),
    .max_clr_n     (max_clr_n),
    .trg_value     (trg_value),
    .limiter       (limiter),
    .bias_ch_A     (bias_ch_A),
    .bias_ch_B     (bias_ch_B),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .trg_count     (trg_count),
    .max_sum       (max_sum)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        user;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    beat_no = 0;

  // Reference model: trigger behaviour described as "beats still blocked" and "waiting for a fall".
  bit          en_m = 1'b0;
  int          skip_m = 0;
  bit          fall_m = 1'b0;
  logic [31:0] cnt_m = 32'd0;
  int          max_m = 0;
  bit          rand_ready = 1'b0;

  function automatic int corr_ref(input int x, input int b);
    int d;
    d = x - b;
    if (d > 32767) return 32767;
    if (d < -32768) return -32768;
    return d;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push_beat(input int a, input int b);
    int    ca, cb, s, lim;
    bit    hit, usr;
    beat_t e;
    ca  = corr_ref(a, int'($signed(bias_ch_A)));
    cb  = corr_ref(b, int'($signed(bias_ch_B)));
    s   = iabs(ca) + iabs(cb);
    hit = (s >= int'(trg_value));
    lim = int'(limiter);
    usr = 1'b0;
    if (en_m) begin
      if (skip_m > 0) begin
        skip_m--;
      end else if (fall_m) begin
        if (!hit) fall_m = 1'b0;
      end else if (hit) begin
        usr    = 1'b1;
        cnt_m  = cnt_m + 32'd1;
        fall_m = 1'b1;
        skip_m = (lim == 0) ? 0 : ((lim > 1) ? lim - 1 : 1);
      end
    end
    if (max_clr_n && s > max_m) max_m = s;
    e.data = {16'(cb), 16'(ca)};
    e.user = usr;
    exp_q.push_back(e);
  endtask

  task automatic send(input int a, input int b);
    int n;
    n = 0;
    s_axis_tdata  = {16'(b), 16'(a)};
    s_axis_tvalid = 1'b1;
    while (1) begin
      @(negedge aclk);
      if (s_axis_tready) break;
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no tready expected tready within 500 cycles");
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    push_beat(a, b);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(negedge aclk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic set_en(input bit v);
    trg_en = v;
    en_m   = v;
    if (!v) begin
      cnt_m  = 32'd0;
      skip_m = 0;
    end else begin
      fall_m = 1'b1;
      skip_m = 0;
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic pulse_clear();
    max_clr_n = 1'b0;
    @(posedge aclk);
    #1;
    max_clr_n = 1'b1;
    max_m     = 0;
  endtask

  function automatic int exp_max();
`ifdef ADC_SUM_TRIGGER_MAX_EN
    return max_m;
`else
    return 0;
`endif
  endfunction

  // Output driver for m_axis_tready.
  always @(posedge aclk) begin
    #1;
    m_axis_tready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Monitor: compares every transferred beat and holds stalled beats steady.
  beat_t       mon_e;
  beat_t       held_b;
  bit          stalled = 1'b0;
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid) begin
      if (stalled) begin
        checks++;
        if (m_axis_tdata !== held_b.data || m_axis_tuser !== held_b.user) begin
          errors++;
          $display("FAIL stall_stable: got %h/%b expected %h/%b",
                   m_axis_tdata, m_axis_tuser, held_b.data, held_b.user);
        end
      end
      if (m_axis_tready) begin
        stalled = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h/%b expected no beat", m_axis_tdata, m_axis_tuser);
        end else begin
          mon_e = exp_q.pop_front();
          if (m_axis_tdata !== mon_e.data || m_axis_tuser !== mon_e.user) begin
            errors++;
            $display("FAIL beat_%0d: got %h/%b expected %h/%b",
                     beat_no, m_axis_tdata, m_axis_tuser, mon_e.data, mon_e.user);
          end else begin
            $display("beat %0d data=%h tuser=%b", beat_no, m_axis_tdata, m_axis_tuser);
          end
        end
        beat_no++;
      end else begin
        stalled     = 1'b1;
        held_b.data = m_axis_tdata;
        held_b.user = m_axis_tuser;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_s_tready", s_axis_tready, 1);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tuser", m_axis_tuser, 0);
    chk("rst_trg_count", trg_count, 0);
    chk("rst_max_sum", max_sum, 0);
    @(posedge aclk);
    #1;

    // Low beats while disabled, then enable: the first high run must fall before firing.
    send(0, 0);
    send(500, 0);
    drain();
    set_en(1'b1);
    send(1200, 0);
    send(1300, 0);
    send(400, 0);
    send(1100, 0);
    drain();
    chk("t1_count_model", trg_count, cnt_m);
    chk("t1_count", trg_count, 1);

    // Saturation corners and the full-scale sum.
    trg_value = 16'hFFFF;
    bias_ch_A = 16'd100;
    send(-32768, 0);
    drain();
    bias_ch_A = 16'hFFFF;
    send(32767, 0);
    drain();
    bias_ch_A = 16'd0;
    send(-32768, -32768);
    send(10, 10);
    send(-32768, -32768);
    drain();
    chk("t2_count", trg_count, cnt_m);

    // Holdoff with limiter=3 on an alternating 2000/0 stream.
    trg_value = 16'd1000;
    limiter   = 8'd3;
    send(0, 0);
    drain();
    c0 = int'(trg_count);
    for (int i = 0; i < 12; i++) send((i % 2 == 0) ? 2000 : 0, 0);
    drain();
    chk("t3_fires", int'(trg_count) - c0, 3);
    chk("t3_count_model", trg_count, cnt_m);

    // Random backpressure over a ramp with random config.
    bias_ch_A  = 16'($urandom_range(0, 4000) - 2000);
    bias_ch_B  = 16'($urandom_range(0, 4000) - 2000);
    trg_value  = 16'($urandom_range(0, 40000));
    limiter    = 8'($urandom_range(0, 6));
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(-32768 + i * 65, int'($urandom_range(0, 65535)) - 32768);
    end
    drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("t4_count_model", trg_count, cnt_m);
    chk("t4_max_sum", max_sum, exp_max());

    // Disable inside holdoff, then re-enable with the signal high.
    bias_ch_A = 16'd0;
    bias_ch_B = 16'd0;
    trg_value = 16'd1000;
    limiter   = 8'd5;
    set_en(1'b0);
    set_en(1'b1);
    send(0, 0);
    send(2000, 0);
    send(2000, 0);
    drain();
    chk("t5_fired", trg_count, 1);
    trg_en = 1'b0;
    en_m   = 1'b0;
    cnt_m  = 32'd0;
    skip_m = 0;
    @(posedge aclk);
    #1;
    chk("t5_count_cleared", trg_count, 0);
    send(3000, 0);
    send(0, 0);
    send(3000, 0);
    drain();
    set_en(1'b1);
    send(3000, 0);
    send(3000, 100);
    send(3000, 0);
    drain();
    chk("t5_no_fire_high", trg_count, 0);
    send(0, 0);
    send(3000, 0);
    drain();
    chk("t5_refire", trg_count, cnt_m);

    // Peak tracking with clears.
    pulse_clear();
    chk("t6_cleared0", max_sum, 0);
    send(3000, 0);
    send(1000, 500);
    drain();
    chk("t6_peak3000", max_sum, exp_max());
    pulse_clear();
    chk("t6_cleared", max_sum, 0);
    send(50, 0);
    drain();
    chk("t6_peak50", max_sum, exp_max());
    max_clr_n = 1'b0;
    send(5000, 5000);
    drain();
    max_clr_n = 1'b1;
    max_m     = 0;
    @(posedge aclk);
    #1;
    chk("t6_clear_wins", max_sum, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
